// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue stage: walks instruction memory with a PC, assembles one- and
// two-word instructions, and handles reset/interrupt vectors, redirects and stalls.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              intr,
  output logic [15:0]       ir_out,
  output logic [15:0]       imm_out,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] next_pc,
  output logic              int_ack,
  output logic [ADDR_W-1:0] int_ret_pc
);

  typedef enum logic [1:0] {StRvec, StFetch, StImm, StIvec} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic              int_pend_q;
  logic              take_int;
  logic              two_word;

  assign pc_inc   = pc_q + ADDR_W'(1);
  // LDM, LDD and STD carry a second immediate word.
  assign two_word = imem_rdata[15:11] inside {5'b00111, 5'b01110, 5'b01111};
  assign take_int = (state_q == StFetch) && !redirect_en && !stall && int_pend_q;

  always_comb begin
    imem_addr = pc_q;
    unique case (state_q)
      StRvec:  imem_addr = RESET_VEC;
      StIvec:  imem_addr = INT_VEC;
      default: imem_addr = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRvec;
      pc_q       <= '0;
      ir_out     <= 16'hF800;
      imm_out    <= '0;
      ir_valid   <= 1'b0;
      next_pc    <= '0;
      int_ack    <= 1'b0;
      int_ret_pc <= '0;
      int_pend_q <= 1'b0;
    end else begin
      // A request arriving in the same cycle as a take stays pending.
      int_pend_q <= (int_pend_q & ~take_int) | intr;
      int_ack    <= 1'b0;
      unique case (state_q)
        StRvec: begin
          pc_q     <= imem_rdata[ADDR_W-1:0];
          ir_valid <= 1'b0;
          state_q  <= StFetch;
        end
        StFetch: begin
          if (redirect_en) begin
            pc_q     <= redirect_pc;
            ir_valid <= 1'b0;
          end else if (stall) begin
            // hold
          end else if (int_pend_q) begin
            int_ret_pc <= pc_q;
            int_ack    <= 1'b1;
            ir_valid   <= 1'b0;
            state_q    <= StIvec;
          end else begin
            ir_out <= imem_rdata;
            pc_q   <= pc_inc;
            if (two_word) begin
              ir_valid <= 1'b0;
              state_q  <= StImm;
            end else begin
              ir_valid <= 1'b1;
              next_pc  <= pc_inc;
            end
          end
        end
        StImm: begin
          if (redirect_en) begin
            pc_q     <= redirect_pc;
            ir_valid <= 1'b0;
            state_q  <= StFetch;
          end else if (!stall) begin
            imm_out  <= imem_rdata;
            pc_q     <= pc_inc;
            next_pc  <= pc_inc;
            ir_valid <= 1'b1;
            state_q  <= StFetch;
          end
        end
        StIvec: begin
          pc_q     <= imem_rdata[ADDR_W-1:0];
          ir_valid <= 1'b0;
          state_q  <= StFetch;
        end
        default: state_q <= StRvec;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios on a 16-bit and a 4-bit PC instance, then
// random programs with random stalls checked against an instruction-stream model.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, redirect_en, intr;
  logic [15:0] redirect_pc, imem_addr, imem_rdata, ir_out, imm_out, next_pc, int_ret_pc;
  logic        ir_valid, int_ack;
  logic [15:0] mem [65536];
  assign imem_rdata = mem[imem_addr];

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .intr(intr), .ir_out(ir_out),
    .imm_out(imm_out), .ir_valid(ir_valid), .next_pc(next_pc), .int_ack(int_ack),
    .int_ret_pc(int_ret_pc)
  );

  logic        rst4, stall4, redirect_en4, intr4, ir_valid4, int_ack4;
  logic [3:0]  redirect_pc4, imem_addr4, next_pc4, int_ret_pc4;
  logic [15:0] imem_rdata4, ir_out4, imm_out4;
  logic [15:0] mem4 [16];
  assign imem_rdata4 = mem4[imem_addr4];

  instr_fetch_unit #(.ADDR_W(4)) dut4 (
    .clk(clk), .rst(rst4), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4), .stall(stall4),
    .redirect_en(redirect_en4), .redirect_pc(redirect_pc4), .intr(intr4), .ir_out(ir_out4),
    .imm_out(imm_out4), .ir_valid(ir_valid4), .next_pc(next_pc4), .int_ack(int_ack4),
    .int_ret_pc(int_ret_pc4)
  );

  int vecs = 0;
  int errs = 0;

  typedef struct {logic [15:0] ir; logic [15:0] imm; logic [15:0] npc;} exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_two(input logic [15:0] w);
    return (w[15:11] == 5'b00111) || (w[15:11] == 5'b01110) || (w[15:11] == 5'b01111);
  endfunction

  initial begin
    logic [15:0] a, w, last_imm, prev_ir;
    logic [4:0]  op;
    logic        prev_stall, prev_v;
    int          n;

    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0; intr = 1'b0;
    rst4 = 1'b1; stall4 = 1'b0; redirect_en4 = 1'b0; redirect_pc4 = '0; intr4 = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
    mem[16'h0000] = 16'h0010; mem[16'h0001] = 16'h0200;
    mem[16'h0010] = 16'hF800; mem[16'h0011] = 16'h0000;
    mem[16'h0012] = 16'h3800; mem[16'h0013] = 16'hBEEF;
    mem[16'h0014] = 16'h7000; mem[16'h0015] = 16'hAAAA;
    mem[16'h0040] = 16'h1234; mem[16'h0050] = 16'h2222;
    mem[16'h0200] = 16'h4321; mem[16'h0201] = 16'h3800; mem[16'h0202] = 16'h5555;

    cyc(); cyc();
    chk("rst_ir", ir_out, 16'hF800);
    chk("rst_imm", imm_out, 16'h0000);
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_npc", next_pc, 16'h0000);
    chk("rst_ack", int_ack, 1'b0);
    chk("rst_retpc", int_ret_pc, 16'h0000);
    chk("rst_addr", imem_addr, 16'h0000);

    rst = 1'b0;
    cyc();
    chk("rvec_valid", ir_valid, 1'b0);
    chk("rvec_pc", imem_addr, 16'h0010);
    cyc();
    chk("nop_ir", ir_out, 16'hF800);
    chk("nop_valid", ir_valid, 1'b1);
    chk("nop_npc", next_pc, 16'h0011);

    stall = 1'b1;
    repeat (3) begin
      cyc();
      chk("stall_ir", ir_out, 16'hF800);
      chk("stall_valid", ir_valid, 1'b1);
      chk("stall_pc", imem_addr, 16'h0011);
    end
    stall = 1'b0;
    cyc();
    chk("resume_ir", ir_out, 16'h0000);
    chk("resume_npc", next_pc, 16'h0012);

    cyc();
    chk("ldm_bubble", ir_valid, 1'b0);
    cyc();
    chk("ldm_ir", ir_out, 16'h3800);
    chk("ldm_imm", imm_out, 16'hBEEF);
    chk("ldm_valid", ir_valid, 1'b1);
    chk("ldm_npc", next_pc, 16'h0014);

    cyc();
    chk("ldd_bubble", ir_valid, 1'b0);
    chk("ldd_immaddr", imem_addr, 16'h0015);
    redirect_en = 1'b1; redirect_pc = 16'h0040;
    cyc();
    chk("abort_valid", ir_valid, 1'b0);
    chk("abort_imm", imm_out, 16'hBEEF);
    chk("abort_pc", imem_addr, 16'h0040);
    redirect_en = 1'b0;
    cyc();
    chk("tgt_ir", ir_out, 16'h1234);
    chk("tgt_valid", ir_valid, 1'b1);
    chk("tgt_npc", next_pc, 16'h0041);

    redirect_en = 1'b1; redirect_pc = 16'h0050;
    cyc();
    chk("flush_valid", ir_valid, 1'b0);
    redirect_en = 1'b0;
    cyc();
    chk("redir_ir", ir_out, 16'h2222);
    chk("redir_npc", next_pc, 16'h0051);

    stall = 1'b1; intr = 1'b1;
    cyc();
    intr = 1'b0;
    cyc();
    chk("int_held_ack", int_ack, 1'b0);
    chk("int_held_ir", ir_out, 16'h2222);
    chk("int_held_valid", ir_valid, 1'b1);
    stall = 1'b0;
    cyc();
    chk("int_ack", int_ack, 1'b1);
    chk("int_retpc", int_ret_pc, 16'h0051);
    chk("int_valid", ir_valid, 1'b0);
    chk("int_vec_addr", imem_addr, 16'h0001);
    cyc();
    chk("ivec_ack", int_ack, 1'b0);
    chk("ivec_retpc", int_ret_pc, 16'h0051);
    chk("ivec_valid", ir_valid, 1'b0);
    cyc();
    chk("isr_ir", ir_out, 16'h4321);
    chk("isr_valid", ir_valid, 1'b1);
    chk("isr_npc", next_pc, 16'h0201);

    cyc();
    chk("imm2_bubble", ir_valid, 1'b0);
    intr = 1'b1; stall = 1'b1;
    cyc();
    chk("imm2_stall_valid", ir_valid, 1'b0);
    intr = 1'b0; rst = 1'b1;
    #1;
    chk("mid_rst_ir", ir_out, 16'hF800);
    chk("mid_rst_imm", imm_out, 16'h0000);
    chk("mid_rst_valid", ir_valid, 1'b0);
    chk("mid_rst_npc", next_pc, 16'h0000);
    chk("mid_rst_retpc", int_ret_pc, 16'h0000);
    chk("mid_rst_addr", imem_addr, 16'h0000);
    rst = 1'b0; stall = 1'b0;
    cyc();
    cyc();
    chk("lost_int_ack", int_ack, 1'b0);
    chk("lost_int_ir", ir_out, 16'hF800);
    chk("lost_int_valid", ir_valid, 1'b1);
    cyc();
    chk("lost_int_ack2", int_ack, 1'b0);
    chk("lost_int_ir2", ir_out, 16'h0000);

    // 4-bit PC: LDM at the last address takes its immediate from address 0.
    mem4[0] = 16'h000F; mem4[1] = 16'h7000; mem4[15] = 16'h3800;
    rst4 = 1'b0;
    cyc();
    cyc();
    chk("w4_bubble", ir_valid4, 1'b0);
    chk("w4_wrap_addr", imem_addr4, 4'h0);
    cyc();
    chk("w4_ir", ir_out4, 16'h3800);
    chk("w4_imm", imm_out4, 16'h000F);
    chk("w4_valid", ir_valid4, 1'b1);
    chk("w4_npc", next_pc4, 4'h1);
    cyc();
    chk("w4_ldd_bubble", ir_valid4, 1'b0);
    chk("w4_ldd_addr", imem_addr4, 4'h2);
    rst4 = 1'b1;
    #1;
    chk("w4_rst_ir", ir_out4, 16'hF800);
    chk("w4_rst_imm", imm_out4, 16'h0000);
    chk("w4_rst_valid", ir_valid4, 1'b0);
    chk("w4_rst_npc", next_pc4, 4'h0);
    chk("w4_rst_addr", imem_addr4, 4'h0);

    // Random program with random stalls; the model is the expected issue stream.
    for (int i = 16'h10; i < 16'hA0; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        case ($urandom_range(0, 2))
          0:       op = 5'b00111;
          1:       op = 5'b01110;
          default: op = 5'b01111;
        endcase
        w = {op, 11'($urandom)};
      end else begin
        w = 16'($urandom);
      end
      mem[i] = w;
    end
    q.delete();
    a = 16'h0010;
    last_imm = 16'h0000;
    repeat (60) begin
      w = mem[a];
      if (is_two(w)) begin
        last_imm = mem[16'(a + 16'd1)];
        a = a + 16'd2;
      end else begin
        a = a + 16'd1;
      end
      q.push_back('{ir: w, imm: last_imm, npc: a});
    end

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    n = 0;
    prev_stall = 1'b0;
    prev_ir = ir_out;
    prev_v = ir_valid;
    for (int c = 0; c < 600 && n < 60; c++) begin
      if (prev_stall) begin
        chk("rnd_hold_ir", ir_out, prev_ir);
        chk("rnd_hold_valid", ir_valid, prev_v);
      end
      stall = ($urandom_range(0, 9) < 3);
      if (ir_valid && !stall) begin
        chk("rnd_ir", ir_out, q[n].ir);
        chk("rnd_imm", imm_out, q[n].imm);
        chk("rnd_npc", next_pc, q[n].npc);
        n++;
      end
      prev_stall = stall;
      prev_ir = ir_out;
      prev_v = ir_valid;
      cyc();
    end
    stall = 1'b0;
    chk("rnd_issue_count", n, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
